// File: rtl/md5_chunk_feeder.sv
// md5_chunk_feeder
//   Message-side front end for md5_chunk_cruncher. Packs a byte stream
//   little-endian into a 16x32-bit chunk buffer and applies MD5 padding
//   (0x80, zero fill, 64-bit little-endian bit length). It serves the
//   cruncher's word reads and sequences one start/done handshake per chunk.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    byte-stream handshake
//   in_data              message byte
//   in_keep              1: beat carries in_data, 0: empty beat (used with in_last)
//   in_last              final beat of the message
//   msg_init             pulse on acceptance of the first beat of a message
//   msg_done             digest on the cruncher output is final
//   start                one-cycle chunk start to the cruncher
//   done                 cruncher done
//   gaddr                word index requested by the cruncher
//   mdata                buffer word at gaddr (combinational)
`timescale 1ns/1ps
module md5_chunk_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_keep,
    input  logic        in_last,
    output logic        msg_init,
    output logic        msg_done,
    output logic        start,
    input  logic        done,
    input  logic [3:0]  gaddr,
    output logic [31:0] mdata
);

    typedef enum logic [2:0] {S_FILL, S_PAD, S_LEN, S_START, S_WAIT} state_t;
    typedef enum logic [1:0] {NA_FILL, NA_PAD, NA_LEN, NA_FINAL} after_t;

    state_t      state, state_nxt;
    after_t      next_after, next_after_nxt;
    logic [31:0] mbuf [16];
    logic [6:0]  pos;
    logic [60:0] cnt;
    logic        first;
    logic        accept;
    logic [63:0] bit_len;

    always_comb begin
        state_nxt      = state;
        next_after_nxt = next_after;
        in_ready       = 1'b0;
        start          = 1'b0;
        case (state)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_keep && pos[5:0] == 6'd63) begin
                        // This byte completes the chunk; a trailing last
                        // still needs a padding chunk afterwards.
                        state_nxt      = S_START;
                        next_after_nxt = in_last ? NA_PAD : NA_FILL;
                    end else if (in_last) begin
                        state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (pos <= 7'd55) begin
                    state_nxt = S_LEN;
                end else begin
                    // No room left for the length words in this chunk.
                    state_nxt      = S_START;
                    next_after_nxt = NA_LEN;
                end
            end
            S_LEN: begin
                state_nxt      = S_START;
                next_after_nxt = NA_FINAL;
            end
            S_START: begin
                start     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    case (next_after)
                        NA_PAD:  state_nxt = S_PAD;
                        NA_LEN:  state_nxt = S_LEN;
                        default: state_nxt = S_FILL;
                    endcase
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_comb begin
        accept   = in_valid & in_ready;
        msg_init = accept & first;
        mdata    = mbuf[gaddr];
        bit_len  = {cnt, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FILL;
            next_after <= NA_FILL;
            pos        <= '0;
            cnt        <= '0;
            first      <= 1'b1;
            msg_done   <= 1'b0;
            mbuf       <= '{default: '0};
        end else begin
            state      <= state_nxt;
            next_after <= next_after_nxt;
            if (accept) begin
                first    <= 1'b0;
                msg_done <= 1'b0;
            end
            case (state)
                S_FILL: begin
                    if (accept && in_keep) begin
                        mbuf[pos[5:2]][{pos[1:0], 3'b000} +: 8] <= in_data;
                        pos <= pos + 7'd1;
                        cnt <= cnt + 61'd1;
                    end
                end
                S_PAD: begin
                    mbuf[pos[5:2]][{pos[1:0], 3'b000} +: 8] <= 8'h80;
                    pos <= pos + 7'd1;
                end
                S_LEN: begin
                    mbuf[14] <= bit_len[31:0];
                    mbuf[15] <= bit_len[63:32];
                end
                S_WAIT: begin
                    if (done) begin
                        mbuf <= '{default: '0};
                        pos  <= '0;
                        if (next_after == NA_FINAL) begin
                            msg_done <= 1'b1;
                            cnt      <= '0;
                            first    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_chunk_feeder.sv
`timescale 1ns/1ps
module tb_md5_chunk_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_keep = 1'b0;
    logic        in_last = 1'b0;
    logic        msg_init;
    logic        msg_done;
    logic        start;
    logic        done = 1'b1;
    logic [3:0]  gaddr = '0;
    logic [31:0] mdata;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int start_cnt = 0;
    int init_cnt = 0;
    int stub_delay = 10;
    int dly = 0;

    md5_chunk_feeder dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_keep  (in_keep),
        .in_last  (in_last),
        .msg_init (msg_init),
        .msg_done (msg_done),
        .start    (start),
        .done     (done),
        .gaddr    (gaddr),
        .mdata    (mdata)
    );

    always #20 clk = ~clk;

    // Stub cruncher: drops done after start, raises it stub_delay cycles later.
    always @(posedge clk) begin
        if (start) begin
            done <= 1'b0;
            dly  <= stub_delay;
        end else if (!done) begin
            if (dly <= 1) done <= 1'b1;
            else          dly  <= dly - 1;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
            if (start)                start_cnt <= start_cnt + 1;
            if (msg_init)             init_cnt <= init_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!start && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (!start) check("start_timeout", 0, 1);
    endtask

    // Step from the START cycle into WAIT.
    task automatic enter_wait();
        @(posedge clk); #1;
    endtask

    task automatic check_chunk(input string tag, input logic [31:0] exp [16]);
        for (int i = 0; i < 16; i++) begin
            gaddr = 4'(i);
            #1;
            check($sformatf("%s_w%0d", tag, i), 64'(mdata), 64'(exp[i]));
        end
    endtask

    task automatic wait_final(input bit in_wait, output int rdy_busy);
        bit waiting;
        bit d;
        int n;
        waiting  = in_wait;
        n        = 0;
        rdy_busy = 0;
        while (n < 500) begin
            if (in_ready && !msg_done) rdy_busy++;
            d = done && waiting;
            if (start) waiting = 1'b1;
            @(posedge clk); #1; n++;
            if (d) break;
            if (msg_done) begin
                check("msg_done_early", 64'(msg_done), 0);
                break;
            end
        end
        check("msg_done_lat", 64'(msg_done), 1);
        check("rdy_after_done", 64'(in_ready), 1);
    endtask

    task automatic do_reset();
        logic [31:0] z [16];
        z = '{default: '0};
        reset = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_init_follows", 64'(msg_init), 1);
        in_valid = 1'b0;
        #1;
        check("rst_init_low", 64'(msg_init), 0);
        reset = 1'b0;
        check("rst_ready", 64'(in_ready), 1);
        check("rst_start", 64'(start), 0);
        check("rst_msg_done", 64'(msg_done), 0);
        check_chunk("rst", z);
    endtask

    initial begin
        logic [31:0] exp_w [16];
        int lat;
        int busy;
        int s0, i0, a0;

        do_reset();

        // "abc"
        s0 = start_cnt; i0 = init_cnt;
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        wait_start(lat);
        check("abc_start_lat", 64'(lat), 2);
        enter_wait();
        exp_w = '{default: '0};
        exp_w[0]  = 32'h80636261;
        exp_w[14] = 32'h00000018;
        check_chunk("abc", exp_w);
        wait_final(1'b1, busy);
        check("abc_starts", 64'(start_cnt - s0), 1);
        check("abc_inits", 64'(init_cnt - i0), 1);

        // Empty message
        s0 = start_cnt;
        send_beat(8'h00, 1'b0, 1'b1);
        wait_start(lat);
        check("empty_start_lat", 64'(lat), 2);
        enter_wait();
        exp_w = '{default: '0};
        exp_w[0] = 32'h00000080;
        check_chunk("empty", exp_w);
        wait_final(1'b1, busy);
        check("empty_starts", 64'(start_cnt - s0), 1);

        // 56 zero bytes: padding spills into a second chunk
        s0 = start_cnt;
        for (int i = 0; i < 56; i++) send_beat(8'h00, 1'b1, (i == 55));
        wait_start(lat);
        check("z56_start_lat", 64'(lat), 1);
        enter_wait();
        exp_w = '{default: '0};
        exp_w[14] = 32'h00000080;
        check_chunk("z56_c1", exp_w);
        wait_start(lat);
        enter_wait();
        exp_w = '{default: '0};
        exp_w[14] = 32'h000001C0;
        check_chunk("z56_c2", exp_w);
        wait_final(1'b1, busy);
        check("z56_starts", 64'(start_cnt - s0), 2);

        // 64 bytes of 0xFF: full chunk then a padding/length chunk
        s0 = start_cnt;
        for (int i = 0; i < 64; i++) send_beat(8'hFF, 1'b1, (i == 63));
        wait_start(lat);
        check("ff_start_lat", 64'(lat), 0);
        enter_wait();
        exp_w = '{default: 32'hFFFFFFFF};
        check_chunk("ff_c1", exp_w);
        wait_start(lat);
        enter_wait();
        exp_w = '{default: '0};
        exp_w[0]  = 32'h00000080;
        exp_w[14] = 32'h00000200;
        check_chunk("ff_c2", exp_w);
        wait_final(1'b1, busy);
        check("ff_starts", 64'(start_cnt - s0), 2);

        // Back-pressure: in_valid held high from the last beat onward
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        in_valid = 1'b1; in_keep = 1'b1; in_last = 1'b0; in_data = 8'h55;
        a0 = acc_cnt;
        wait_final(1'b0, busy);
        check("bp_ready_busy", 64'(busy), 0);
        check("bp_no_accept", 64'(acc_cnt), 64'(a0));
        check("bp_init_pulse", 64'(msg_init), 1);
        @(posedge clk); #1;
        check("bp_done_clr", 64'(msg_done), 0);
        check("bp_accept", 64'(acc_cnt), 64'(a0 + 1));
        in_valid = 1'b0; in_keep = 1'b0;

        // Reset asserted while waiting on the cruncher
        do_reset();
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        wait_start(lat);
        enter_wait();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("wrst_ready", 64'(in_ready), 1);
        check("wrst_start", 64'(start), 0);
        check("wrst_msg_done", 64'(msg_done), 0);
        exp_w = '{default: '0};
        check_chunk("wrst", exp_w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
